// File: rtl/cve2_obi_mem_responder_if.sv
// rtl/cve2_obi_mem_responder_if.sv - OBI-style req/gnt/rvalid bus bundle between core and memory responder
// Signals: req/we/be/addr/wdata driven by the requester (master),
//          gnt/rvalid/rdata/err driven by the responder (slave).
interface cve2_obi_mem_responder_if;
    logic        req;
    logic        gnt;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/cve2_obi_mem_responder.sv
// rtl/cve2_obi_mem_responder.sv - OBI responder in front of a fixed-latency single-port SRAM
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   bus (slave modport)  req/gnt/we/be/addr/wdata request side, rvalid/rdata/err response side
//   mem_req_o/mem_gnt_i  SRAM access strobe and SRAM-port-available
//   mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o  SRAM write/address/bit-mask/data
//   mem_rdata_i          SRAM read data, valid MemLatency cycles after the access
module cve2_obi_mem_responder #(
    parameter logic [31:0] AddrBase       = 32'h3000_0000,
    parameter int unsigned AddrWords      = 512,
    parameter int unsigned MemLatency     = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    cve2_obi_mem_responder_if.slave      bus,
    output logic                         mem_req_o,
    input  logic                         mem_gnt_i,
    output logic                         mem_we_o,
    output logic [$clog2(AddrWords)-1:0] mem_addr_o,
    output logic [31:0]                  mem_wmask_o,
    output logic [31:0]                  mem_wdata_o,
    input  logic [31:0]                  mem_rdata_i
);
    localparam int unsigned AW = $clog2(AddrWords);
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);

    // Range arithmetic is done 33 bits wide so a window near the top of
    // the address space cannot wrap around to look in-range.
    localparam logic [32:0] BaseExt     = {1'b0, AddrBase};
    localparam logic [32:0] WindowBytes = 33'(AddrWords) << 2;
    localparam logic [CW:0] MaxOut      = MaxOutstanding[CW:0];

    logic [32:0] addr_ext;
    logic [32:0] offset;
    logic        in_range;
    logic        bad;
    logic [CW:0] inflight;
    logic        slot_ok;
    logic        gnt;
    logic        mem_req;

    logic [CW-1:0] cnt_q, cnt_d;

    // Response pipeline: one {valid, err, we} entry per cycle of SRAM latency.
    logic [MemLatency-1:0] pv_q, pv_d;
    logic [MemLatency-1:0] pe_q, pe_d;
    logic [MemLatency-1:0] pw_q, pw_d;

    logic resp_valid;
    logic resp_err;
    logic resp_we;

    assign resp_valid = pv_q[MemLatency-1];
    assign resp_err   = pe_q[MemLatency-1];
    assign resp_we    = pw_q[MemLatency-1];

    always_comb begin
        addr_ext = {1'b0, bus.addr[31:2], 2'b00};
        offset   = addr_ext - BaseExt;
        in_range = (addr_ext >= BaseExt) && (offset < WindowBytes);
        bad      = !in_range || (bus.be == 4'b0000);

        // A response leaving this cycle frees its slot right away, which
        // keeps full throughput when MaxOutstanding >= MemLatency.
        inflight = {1'b0, cnt_q} - {{CW{1'b0}}, resp_valid};
        slot_ok  = inflight < MaxOut;

        // Error requests are answered from the pipeline alone, so they
        // never wait for the SRAM port.
        gnt      = bus.req && slot_ok && (bad || mem_gnt_i);
        mem_req  = bus.req && slot_ok && !bad && mem_gnt_i;
    end

    always_comb begin
        pv_d    = '0;
        pe_d    = '0;
        pw_d    = '0;
        pv_d[0] = gnt;
        pe_d[0] = bad;
        pw_d[0] = bus.we;
        for (int i = 1; i < int'(MemLatency); i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
            pw_d[i] = pw_q[i-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (gnt && !resp_valid) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!gnt && resp_valid) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv_q  <= '0;
            pe_q  <= '0;
            pw_q  <= '0;
            cnt_q <= '0;
        end else begin
            pv_q  <= pv_d;
            pe_q  <= pe_d;
            pw_q  <= pw_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = resp_valid;
    assign bus.err    = resp_err;
    assign bus.rdata  = (resp_valid && !resp_err && !resp_we) ? mem_rdata_i : 32'h0;

    assign mem_req_o   = mem_req;
    assign mem_we_o    = bus.we;
    assign mem_addr_o  = offset[AW+1:2];
    assign mem_wmask_o = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
    assign mem_wdata_o = bus.wdata;

    logic unused_bits;
    assign unused_bits = ^{bus.addr[1:0], offset[32:AW+2], offset[1:0]};
endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// tb/tb_cve2_obi_mem_responder.sv - directed bench for cve2_obi_mem_responder (latency 1 and latency 3 instances)
module tb_cve2_obi_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    cve2_obi_mem_responder_if a_if ();
    cve2_obi_mem_responder_if b_if ();

    logic        mem_req_a, mem_gnt_a, mem_we_a;
    logic [8:0]  mem_addr_a;
    logic [31:0] mem_wmask_a, mem_wdata_a, mem_rdata_a;

    logic        mem_req_b, mem_gnt_b, unused_we_b;
    logic [8:0]  mem_addr_b;
    logic [31:0] unused_wmask_b, unused_wdata_b, mem_rdata_b;

    cve2_obi_mem_responder #(
        .AddrBase(32'h3000_0000), .AddrWords(512), .MemLatency(1), .MaxOutstanding(2)
    ) u_a (
        .clk_i(clk), .rst_ni(rst_a_n), .bus(a_if),
        .mem_req_o(mem_req_a), .mem_gnt_i(mem_gnt_a), .mem_we_o(mem_we_a),
        .mem_addr_o(mem_addr_a), .mem_wmask_o(mem_wmask_a), .mem_wdata_o(mem_wdata_a),
        .mem_rdata_i(mem_rdata_a)
    );

    cve2_obi_mem_responder #(
        .AddrBase(32'h3000_0000), .AddrWords(512), .MemLatency(3), .MaxOutstanding(2)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_b_n), .bus(b_if),
        .mem_req_o(mem_req_b), .mem_gnt_i(mem_gnt_b), .mem_we_o(unused_we_b),
        .mem_addr_o(mem_addr_b), .mem_wmask_o(unused_wmask_b), .mem_wdata_o(unused_wdata_b),
        .mem_rdata_i(mem_rdata_b)
    );

    // SRAM model A: latency 1, bit-masked writes.
    logic [31:0] mem_a [512];
    always @(posedge clk) begin
        if (mem_req_a) begin
            if (mem_we_a) mem_a[mem_addr_a] <= (mem_a[mem_addr_a] & ~mem_wmask_a) | (mem_wdata_a & mem_wmask_a);
            else          mem_rdata_a <= mem_a[mem_addr_a];
        end
    end

    // SRAM model B: latency 3, read-only, preloaded with 0xB000_0000 + index.
    logic [31:0] mem_b [512];
    logic [31:0] rb0, rb1, rb2;
    initial for (int i = 0; i < 512; i++) mem_b[i] = 32'hB000_0000 + i;
    always @(posedge clk) begin
        rb0 <= mem_req_b ? mem_b[mem_addr_b] : 32'h0;
        rb1 <= rb0;
        rb2 <= rb1;
    end
    assign mem_rdata_b = rb2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic a_drive(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        a_if.req = 1'b1; a_if.we = we; a_if.be = be; a_if.addr = addr; a_if.wdata = wdata;
    endtask

    // Called one delta after a_drive within the same cycle: checks grant and
    // SRAM strobe, then the response one cycle later.
    task automatic a_finish(input string tag, input logic exp_err, input logic [31:0] exp_rdata);
        check({tag, ".gnt"}, 32'(a_if.gnt), 32'd1);
        check({tag, ".mem_req"}, 32'(mem_req_a), 32'(!exp_err));
        @(posedge clk); #1;
        a_if.req = 1'b0;
        #1;
        check({tag, ".rvalid"}, 32'(a_if.rvalid), 32'd1);
        check({tag, ".err"}, 32'(a_if.err), 32'(exp_err));
        check({tag, ".rdata"}, a_if.rdata, exp_rdata);
    endtask

    // Throttle expectations for the latency-3 instance, cycles 0..8.
    logic [8:0] exp_g  = 9'b000_011_011;
    logic [8:0] exp_rv = 9'b011_011_000;

    initial begin
        int ng;
        int nr;
        int exp_cnt;

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.be = 4'h0; a_if.addr = 32'h0; a_if.wdata = 32'h0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.be = 4'h0; b_if.addr = 32'h0; b_if.wdata = 32'h0;
        mem_gnt_a = 1'b1; mem_gnt_b = 1'b1;

        #12;
        check("rst.a.rvalid", 32'(a_if.rvalid), 32'd0);
        check("rst.a.err", 32'(a_if.err), 32'd0);
        check("rst.a.rdata", a_if.rdata, 32'h0);
        check("rst.b.rvalid", 32'(b_if.rvalid), 32'd0);
        @(posedge clk); #1;
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(posedge clk); #1;

        // Read after write.
        a_drive(1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF); #1;
        check("raw.wr.mem_addr", 32'(mem_addr_a), 32'd4);
        a_finish("raw.wr", 1'b0, 32'h0);
        a_drive(1'b0, 4'hF, 32'h3000_0010, 32'h0); #1;
        check("raw.rd.mem_addr", 32'(mem_addr_a), 32'd4);
        a_finish("raw.rd", 1'b0, 32'hDEAD_BEEF);

        // Byte enables over an all-ones word.
        a_drive(1'b1, 4'hF, 32'h3000_0020, 32'hFFFF_FFFF); #1;
        a_finish("be.fill", 1'b0, 32'h0);
        a_drive(1'b1, 4'b0101, 32'h3000_0020, 32'h1122_3344); #1;
        check("be.wmask", mem_wmask_a, 32'h00FF_00FF);
        a_finish("be.wr", 1'b0, 32'h0);
        a_drive(1'b0, 4'hF, 32'h3000_0020, 32'h0); #1;
        a_finish("be.rd", 1'b0, 32'hFF22_FF44);

        // Last word of the window is still in range.
        a_drive(1'b1, 4'hF, 32'h3000_07FF, 32'h0BAD_F00D); #1;
        check("last.mem_addr", 32'(mem_addr_a), 32'd511);
        a_finish("last.wr", 1'b0, 32'h0);
        a_drive(1'b0, 4'hF, 32'h3000_07FC, 32'h0); #1;
        a_finish("last.rd", 1'b0, 32'h0BAD_F00D);

        // Error accesses; the be==0 one runs with the SRAM port unavailable.
        a_drive(1'b0, 4'hF, 32'h2FFF_FFFC, 32'h0); #1;
        a_finish("err.below", 1'b1, 32'h0);
        a_drive(1'b1, 4'hF, 32'h3000_0800, 32'h1234_5678); #1;
        a_finish("err.past", 1'b1, 32'h0);
        a_drive(1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0); #1;
        a_finish("err.top", 1'b1, 32'h0);
        mem_gnt_a = 1'b0;
        a_drive(1'b0, 4'h0, 32'h3000_0010, 32'h0); #1;
        a_finish("err.be0", 1'b1, 32'h0);
        mem_gnt_a = 1'b1;
        @(posedge clk); #1;

        // SRAM stall: in-range read held 3 cycles, error request behind it.
        mem_gnt_a = 1'b0;
        a_drive(1'b0, 4'hF, 32'h3000_0010, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall.gnt", 32'(a_if.gnt), 32'd0);
            check("stall.mem_req", 32'(mem_req_a), 32'd0);
            @(posedge clk); #1;
        end
        mem_gnt_a = 1'b1; #1;
        check("stall.release.gnt", 32'(a_if.gnt), 32'd1);
        @(posedge clk); #1;
        a_drive(1'b0, 4'hF, 32'h4000_0000, 32'h0); #1;
        check("stall.rd.rvalid", 32'(a_if.rvalid), 32'd1);
        check("stall.rd.err", 32'(a_if.err), 32'd0);
        check("stall.rd.rdata", a_if.rdata, 32'hDEAD_BEEF);
        check("stall.err.gnt", 32'(a_if.gnt), 32'd1);
        @(posedge clk); #1;
        a_if.req = 1'b0; #1;
        check("stall.err.rvalid", 32'(a_if.rvalid), 32'd1);
        check("stall.err.err", 32'(a_if.err), 32'd1);
        @(posedge clk); #2;
        check("stall.idle.rvalid", 32'(a_if.rvalid), 32'd0);

        // Throttle on the latency-3 / two-outstanding instance.
        ng = 0; nr = 0; exp_cnt = 0;
        b_if.we = 1'b0; b_if.be = 4'hF;
        for (int c = 0; c < 9; c++) begin
            b_if.req  = (c < 6);
            b_if.addr = 32'h3000_0000 + 32'(4 * (1 + ng));
            #1;
            check($sformatf("thr.c%0d.gnt", c), 32'(b_if.gnt), 32'(exp_g[c]));
            check($sformatf("thr.c%0d.rvalid", c), 32'(b_if.rvalid), 32'(exp_rv[c]));
            check($sformatf("thr.c%0d.rdata", c), b_if.rdata,
                  exp_rv[c] ? 32'hB000_0001 + 32'(nr) : 32'h0);
            check($sformatf("thr.c%0d.cnt", c), 32'(u_b.cnt_q), 32'(exp_cnt));
            if (exp_rv[c]) nr++;
            if (exp_g[c]) ng++;
            exp_cnt = exp_cnt + int'(exp_g[c]) - int'(exp_rv[c]);
            @(posedge clk); #1;
        end

        // Reset one cycle after the second read grant, with both slots full.
        b_if.req = 1'b1; b_if.addr = 32'h3000_0014; #1;
        check("rst.g0", 32'(b_if.gnt), 32'd1);
        @(posedge clk); #1;
        b_if.addr = 32'h3000_0018; #1;
        check("rst.g1", 32'(b_if.gnt), 32'd1);
        @(posedge clk); #1;
        b_if.req = 1'b0;
        rst_b_n = 1'b0; #1;
        check("rst.mid.rvalid", 32'(b_if.rvalid), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rst.after%0d.rvalid", k), 32'(b_if.rvalid), 32'd0);
            @(posedge clk); #1;
        end
        b_if.req = 1'b1; b_if.addr = 32'h3000_001C; #1;
        check("rst.next.gnt", 32'(b_if.gnt), 32'd1);
        @(posedge clk); #1;
        b_if.req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("rst.next.rvalid", 32'(b_if.rvalid), 32'd1);
        check("rst.next.rdata", b_if.rdata, 32'hB000_0007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
